visor_fetch: RTL and testbench

Instruction fetch stage for the supervisor (visor) MCU. It sits directly upstream of the visor program ROM: it drives the ROM word address, captures the returned word, and assembles one- and two-word instructions. It issues each complete instruction, plus its immediate, to the visor decode/execute stage. It also accepts redirects (jmp/br taken) and stalls from execute.

---
 rtl/visor_fetch.sv | 74 +++++++
 tb/tb_visor_fetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/visor_fetch.sv
// Fetch stage for the visor MCU: drives the ROM address and assembles one- and two-word instructions.
// Latency 1 clk (one-word) / 2 clks (two-word). stall freezes fetch; redirect overrides stall.
module visor_fetch #(
  parameter logic [15:0] RESET_ADDR = 16'h0000,
  parameter logic [15:0] NOP_WORD   = 16'hc800
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] code_addr,
  input  logic [15:0] code_content,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_addr,
  output logic [15:0] exr,
  output logic [15:0] imm,
  output logic        issue,
  output logic [15:0] pc,
  output logic [15:0] issue_count
);

  typedef enum logic {ST_OP, ST_IMM} state_t;

  state_t      state;
  logic [15:0] op_hold;
  logic        two_word;

  // jmp/br family and fetch-literal carry a trailing immediate word
  assign two_word  = (code_content[15:13] == 3'b111) || (code_content[15:12] == 4'hd);
  assign code_addr = pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_ADDR;
      exr         <= NOP_WORD;
      imm         <= 16'h0000;
      issue       <= 1'b0;
      issue_count <= 16'h0000;
      op_hold     <= 16'h0000;
      state       <= ST_OP;
    end else begin
      issue <= 1'b0;
      if (redirect) begin
        // a partial two-word instruction is dropped; exr/imm keep the last issue
        pc      <= redirect_addr;
        state   <= ST_OP;
        op_hold <= 16'h0000;
      end else if (!stall) begin
        pc <= pc + 16'h0001;
        case (state)
          ST_OP: begin
            if (two_word) begin
              op_hold <= code_content;
              state   <= ST_IMM;
            end else begin
              exr         <= code_content;
              imm         <= 16'h0000;
              issue       <= 1'b1;
              issue_count <= issue_count + 16'h0001;
            end
          end
          ST_IMM: begin
            exr         <= op_hold;
            imm         <= code_content;
            issue       <= 1'b1;
            issue_count <= issue_count + 16'h0001;
            state       <= ST_OP;
          end
          default: state <= ST_OP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_visor_fetch.sv
// Directed bench for visor_fetch: a vector table of per-cycle inputs and expected outputs plus a reset sequence.
module tb_visor_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] code_addr;
  logic [15:0] code_content;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_addr;
  logic [15:0] exr;
  logic [15:0] imm;
  logic        issue;
  logic [15:0] pc;
  logic [15:0] issue_count;

  logic [15:0] rom [0:65535];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign code_content = rom[code_addr];

  visor_fetch dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .code_addr     (code_addr),
    .code_content  (code_content),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .exr           (exr),
    .imm           (imm),
    .issue         (issue),
    .pc            (pc),
    .issue_count   (issue_count)
  );

  typedef struct {
    logic        st;
    logic        rd;
    logic [15:0] raddr;
    logic [15:0] e_exr;
    logic [15:0] e_imm;
    logic        e_iss;
    logic [15:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [23];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_exr, input logic [15:0] e_imm,
                           input logic e_iss, input logic [15:0] e_pc, input logic [15:0] e_cnt);
    check({tag, " exr"}, exr, e_exr);
    check({tag, " imm"}, imm, e_imm);
    check({tag, " issue"}, {15'd0, issue}, {15'd0, e_iss});
    check({tag, " pc"}, pc, e_pc);
    check({tag, " code_addr"}, code_addr, e_pc);
    check({tag, " issue_count"}, issue_count, e_cnt);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) rom[a] = 16'h0100;
    rom[16'h0000] = 16'h3a02;
    rom[16'h0006] = 16'he005;
    rom[16'h0007] = 16'h0006;
    rom[16'h0009] = 16'h0200;
    rom[16'h000c] = 16'he004;
    rom[16'h0010] = 16'hd223;
    rom[16'h0011] = 16'h33b0;
    rom[16'h001c] = 16'h7c00;
    rom[16'hffff] = 16'h1234;

    //          st rd raddr     exr       imm       iss pc        cnt
    vecs[0]  = '{0, 0, 16'h0000, 16'h3a02, 16'h0000, 1, 16'h0001, 16'd1};
    vecs[1]  = '{0, 1, 16'h0006, 16'h3a02, 16'h0000, 0, 16'h0006, 16'd1};
    vecs[2]  = '{0, 0, 16'h0000, 16'h3a02, 16'h0000, 0, 16'h0007, 16'd1};
    vecs[3]  = '{0, 0, 16'h0000, 16'he005, 16'h0006, 1, 16'h0008, 16'd2};
    vecs[4]  = '{0, 1, 16'h0006, 16'he005, 16'h0006, 0, 16'h0006, 16'd2};
    vecs[5]  = '{0, 0, 16'h0000, 16'he005, 16'h0006, 0, 16'h0007, 16'd2};
    vecs[6]  = '{0, 0, 16'h0000, 16'he005, 16'h0006, 1, 16'h0008, 16'd3};
    vecs[7]  = '{0, 1, 16'h0010, 16'he005, 16'h0006, 0, 16'h0010, 16'd3};
    vecs[8]  = '{0, 0, 16'h0000, 16'he005, 16'h0006, 0, 16'h0011, 16'd3};
    vecs[9]  = '{1, 0, 16'h0000, 16'he005, 16'h0006, 0, 16'h0011, 16'd3};
    vecs[10] = '{1, 0, 16'h0000, 16'he005, 16'h0006, 0, 16'h0011, 16'd3};
    vecs[11] = '{1, 0, 16'h0000, 16'he005, 16'h0006, 0, 16'h0011, 16'd3};
    vecs[12] = '{0, 0, 16'h0000, 16'hd223, 16'h33b0, 1, 16'h0012, 16'd4};
    vecs[13] = '{0, 1, 16'h000c, 16'hd223, 16'h33b0, 0, 16'h000c, 16'd4};
    vecs[14] = '{0, 0, 16'h0000, 16'hd223, 16'h33b0, 0, 16'h000d, 16'd4};
    vecs[15] = '{0, 1, 16'h0009, 16'hd223, 16'h33b0, 0, 16'h0009, 16'd4};
    vecs[16] = '{0, 0, 16'h0000, 16'h0200, 16'h0000, 1, 16'h000a, 16'd5};
    vecs[17] = '{1, 1, 16'h001c, 16'h0200, 16'h0000, 0, 16'h001c, 16'd5};
    vecs[18] = '{1, 0, 16'h0000, 16'h0200, 16'h0000, 0, 16'h001c, 16'd5};
    vecs[19] = '{0, 0, 16'h0000, 16'h7c00, 16'h0000, 1, 16'h001d, 16'd6};
    vecs[20] = '{1, 0, 16'h0000, 16'h7c00, 16'h0000, 0, 16'h001d, 16'd6};
    vecs[21] = '{0, 1, 16'hffff, 16'h7c00, 16'h0000, 0, 16'hffff, 16'd6};
    vecs[22] = '{0, 0, 16'h0000, 16'h1234, 16'h0000, 1, 16'h0000, 16'd7};

    reset_n       = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_addr = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all("reset", 16'hc800, 16'h0000, 1'b0, 16'h0000, 16'd0);

    for (int i = 0; i < 23; i++) begin
      stall         = vecs[i].st;
      redirect      = vecs[i].rd;
      redirect_addr = vecs[i].raddr;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_exr, vecs[i].e_imm, vecs[i].e_iss,
                vecs[i].e_pc, vecs[i].e_cnt);
    end

    // Enter IMM on e005, then assert reset between edges
    stall         = 1'b0;
    redirect      = 1'b1;
    redirect_addr = 16'h0006;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(posedge clk);
    #1;
    check_all("pre_rst_imm", 16'h1234, 16'h0000, 1'b0, 16'h0007, 16'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 16'hc800, 16'h0000, 1'b0, 16'h0000, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", 16'h3a02, 16'h0000, 1'b1, 16'h0001, 16'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
